// File: rtl/fifo_rd_unpacker.sv
// Pops 560-bit words from the async FIFO read side and emits them as ten 56-bit beats, LS slice first.
// Latency: r_en in cycle T -> first beat valid in T+2; one bubble cycle between back-to-back words.
// Backpressure: m_ready low freezes the beat and index; no pop except on a word's final handshake.
module fifo_rd_unpacker #(
    parameter int IN_W  = 560,
    parameter int OUT_W = 56,
    parameter int CNT_W = 16
) (
    input  logic             r_clk,
    input  logic             rst_n,
    input  logic             r_empty,
    input  logic [IN_W-1:0]  r_data,
    output logic             r_en,
    output logic [OUT_W-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_first,
    output logic             m_last,
    output logic [CNT_W-1:0] word_cnt
);
    localparam int BEATS = IN_W / OUT_W;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t           state;
    logic [IN_W-1:0]  shift_reg;
    logic [IDX_W-1:0] idx;
    logic             beat_hs;
    logic             last_hs;

    assign beat_hs = (state == SEND) && m_valid && m_ready;
    assign last_hs = beat_hs && (idx == LAST_IDX);

    // The only pop outside IDLE is on the final handshake, which keeps the single-word buffer from overflowing.
    assign r_en   = rst_n && !r_empty && ((state == IDLE) || last_hs);
    assign m_data = shift_reg[OUT_W-1:0];

    always_ff @(posedge r_clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            idx       <= '0;
            m_valid   <= 1'b0;
            m_first   <= 1'b0;
            m_last    <= 1'b0;
            word_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (r_en) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    shift_reg <= r_data;
                    idx       <= '0;
                    m_valid   <= 1'b1;
                    m_first   <= 1'b1;
                    m_last    <= (BEATS == 1);
                    state     <= SEND;
                end
                SEND: begin
                    if (last_hs) begin
                        word_cnt <= word_cnt + 1'b1;
                        m_valid  <= 1'b0;
                        m_first  <= 1'b0;
                        m_last   <= 1'b0;
                        state    <= r_en ? LOAD : IDLE;
                    end else if (beat_hs) begin
                        shift_reg <= shift_reg >> OUT_W;
                        idx       <= idx + 1'b1;
                        m_first   <= 1'b0;
                        m_last    <= ((idx + 1'b1) == LAST_IDX);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Bench for fifo_rd_unpacker: queue-based FIFO and beat-stream model, checked every cycle on the falling edge.
module tb_fifo_rd_unpacker;
    localparam int IN_W  = 560;
    localparam int OUT_W = 56;
    localparam int BEATS = 10;
    localparam int CNT_W = 16;

    logic             r_clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             r_empty;
    logic [IN_W-1:0]  r_data = '0;
    logic             r_en;
    logic [OUT_W-1:0] m_data;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic             m_first;
    logic             m_last;
    logic [CNT_W-1:0] word_cnt;

    always #5 r_clk = ~r_clk;

    fifo_rd_unpacker #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .r_clk(r_clk), .rst_n(rst_n), .r_empty(r_empty), .r_data(r_data), .r_en(r_en),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_first(m_first),
        .m_last(m_last), .word_cnt(word_cnt)
    );

    // Upstream FIFO: data appears the cycle after a pop; reset flushes it.
    logic [IN_W-1:0] mem [0:63];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    logic empty_ovr = 1'b0;
    assign r_empty = empty_ovr ? 1'b0 : (wr_ptr == rd_ptr);

    always @(posedge r_clk) begin
        if (!rst_n) rd_ptr <= wr_ptr;
        else if (r_en && wr_ptr != rd_ptr) begin
            r_data <= mem[rd_ptr % 64];
            rd_ptr <= rd_ptr + 1;
        end
    end

    typedef struct packed {
        logic [OUT_W-1:0] d;
        logic             first;
        logic             last;
    } beat_t;

    beat_t            exp_q[$];
    bit               busy = 1'b0;
    int               send_cyc = 0;
    int               cyc = 0;
    logic [CNT_W-1:0] mdl_cnt = '0;
    int               checks = 0;
    int               failures = 0;
    bit               prev_stall = 1'b0;
    beat_t            prev_b;
    int               ren_log[$];
    int               first_log[$];
    int               last_log[$];
    logic [OUT_W-1:0] rx_log[$];
    logic             mv_exp, ren_exp, last_exp;
    beat_t            nb;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [IN_W-1:0] make_word(input int tag, input bit plain);
        logic [IN_W-1:0] w;
        w = '0;
        for (int k = 0; k < BEATS; k++)
            w[k*OUT_W +: OUT_W] = plain ? OUT_W'(k) : {8'(tag), 40'h0, 8'(k)};
        return w;
    endfunction

    // Model: a popped word becomes ten expected beats, valid from pop+2 until its last beat is taken.
    always @(negedge r_clk) begin
        cyc++;
        if (!rst_n) begin
            chk("ren_in_reset", {63'h0, r_en}, 64'h0);
            exp_q.delete();
            busy = 1'b0;
            mdl_cnt = '0;
            prev_stall = 1'b0;
        end else begin
            mv_exp = busy && (cyc >= send_cyc);
            chk("m_valid", {63'h0, m_valid}, {63'h0, mv_exp});
            chk("word_cnt", {48'h0, word_cnt}, {48'h0, mdl_cnt});
            chk("ren_while_empty", {63'h0, r_en & r_empty}, 64'h0);
            last_exp = mv_exp && m_ready && exp_q.size() > 0 && exp_q[0].last;
            ren_exp = !r_empty && (!busy || last_exp);
            chk("r_en", {63'h0, r_en}, {63'h0, ren_exp});
            if (mv_exp && m_valid) begin
                if (exp_q.size() == 0) begin
                    chk("beat_underrun", {63'h0, m_valid}, 64'h0);
                end else begin
                    chk("m_data", {8'h0, m_data}, {8'h0, exp_q[0].d});
                    chk("m_first", {63'h0, m_first}, {63'h0, exp_q[0].first});
                    chk("m_last", {63'h0, m_last}, {63'h0, exp_q[0].last});
                    if (prev_stall)
                        chk("stall_hold", {6'h0, m_data, m_first, m_last}, {6'h0, prev_b});
                    if (m_ready) begin
                        rx_log.push_back(m_data);
                        if (exp_q[0].first) first_log.push_back(cyc);
                        if (exp_q[0].last) begin
                            last_log.push_back(cyc);
                            mdl_cnt = mdl_cnt + 1'b1;
                            busy = 1'b0;
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_b = '{d: m_data, first: m_first, last: m_last};
            if (r_en) begin
                ren_log.push_back(cyc);
                busy = 1'b1;
                send_cyc = cyc + 2;
                for (int k = 0; k < BEATS; k++) begin
                    nb.d = mem[rd_ptr % 64][k*OUT_W +: OUT_W];
                    nb.first = (k == 0);
                    nb.last = (k == BEATS - 1);
                    exp_q.push_back(nb);
                end
            end
        end
    end

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic push(input logic [IN_W-1:0] w);
        mem[wr_ptr % 64] = w;
        wr_ptr++;
    endtask

    task automatic clear_logs();
        ren_log.delete(); first_log.delete(); last_log.delete(); rx_log.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || wr_ptr != rd_ptr) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) chk("idle_timeout", 64'(n), 64'(budget - 1));
    endtask

    initial begin
        logic [3:0] pat;
        int n;
        pat = 4'b1001;

        // Reset with a non-empty flag, then idle with an empty FIFO
        empty_ovr = 1'b1;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        empty_ovr = 1'b0;
        repeat (3) tick();
        chk("idle_valid", {63'h0, m_valid}, 64'h0);
        chk("idle_cnt", {48'h0, word_cnt}, 64'h0);
        chk("idle_ren", {63'h0, r_en}, 64'h0);

        // Single word, slices 0..9
        clear_logs();
        push(make_word(0, 1'b1));
        wait_idle(60);
        chk("single_pops", 64'(ren_log.size()), 64'd1);
        chk("single_beats", 64'(rx_log.size()), 64'd10);
        if (ren_log.size() == 1 && first_log.size() == 1 && last_log.size() == 1) begin
            chk("single_first_lat", 64'(first_log[0] - ren_log[0]), 64'd2);
            chk("single_last_lat", 64'(last_log[0] - ren_log[0]), 64'd11);
        end
        for (int k = 0; k < BEATS && k < rx_log.size(); k++)
            chk("single_beat", {8'h0, rx_log[k]}, 64'(k));
        chk("single_cnt", {48'h0, word_cnt}, 64'd1);

        // Three words back to back
        clear_logs();
        for (int w = 1; w <= 3; w++) push(make_word(w, 1'b0));
        wait_idle(120);
        chk("b2b_pops", 64'(ren_log.size()), 64'd3);
        if (ren_log.size() == 3) begin
            chk("b2b_gap1", 64'(ren_log[1] - ren_log[0]), 64'd11);
            chk("b2b_gap2", 64'(ren_log[2] - ren_log[0]), 64'd22);
        end
        if (first_log.size() == 3 && last_log.size() == 3)
            chk("b2b_bubble", 64'(first_log[1] - last_log[0]), 64'd2);
        chk("b2b_beats", 64'(rx_log.size()), 64'd30);
        chk("b2b_cnt", {48'h0, word_cnt}, 64'd4);

        // Backpressure pattern 1,0,0,1
        clear_logs();
        push(make_word(8'h5A, 1'b0));
        n = 0;
        while ((busy || wr_ptr != rd_ptr) && n < 200) begin
            m_ready = pat[n % 4];
            tick();
            n++;
        end
        m_ready = 1'b1;
        chk("bp_pops", 64'(ren_log.size()), 64'd1);
        chk("bp_beats", 64'(rx_log.size()), 64'd10);
        for (int k = 0; k < BEATS && k < rx_log.size(); k++)
            chk("bp_beat", {8'h0, rx_log[k]}, {8'h0, 8'h5A, 40'h0, 8'(k)});
        chk("bp_cnt", {48'h0, word_cnt}, 64'd5);

        // Counter wrap
        force dut.word_cnt = 16'hFFFE;
        mdl_cnt = 16'hFFFE;
        tick();
        release dut.word_cnt;
        tick();
        push(make_word(10, 1'b0));
        wait_idle(60);
        chk("wrap_ffff", {48'h0, word_cnt}, 64'hFFFF);
        push(make_word(11, 1'b0));
        wait_idle(60);
        chk("wrap_0000", {48'h0, word_cnt}, 64'h0000);
        push(make_word(12, 1'b0));
        wait_idle(60);
        chk("wrap_0001", {48'h0, word_cnt}, 64'h0001);

        // Reset after beat 4 is accepted
        clear_logs();
        push(make_word(8'h77, 1'b0));
        n = 0;
        while (rx_log.size() < 5 && n < 60) begin
            tick();
            n++;
        end
        chk("rst_reach_beat4", 64'(rx_log.size()), 64'd5);
        rst_n = 1'b0;
        tick();
        chk("rst_valid", {63'h0, m_valid}, 64'h0);
        chk("rst_cnt", {48'h0, word_cnt}, 64'h0);
        rst_n = 1'b1;
        tick();
        clear_logs();
        push(make_word(8'h33, 1'b0));
        wait_idle(60);
        chk("post_rst_beats", 64'(rx_log.size()), 64'd10);
        if (rx_log.size() > 0)
            chk("post_rst_beat0", {8'h0, rx_log[0]}, {8'h0, 8'h33, 48'h0});
        chk("post_rst_cnt", {48'h0, word_cnt}, 64'd1);

        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
